secuenciador_bias: RTL

- Sequencer directly downstream of the GARO bias meter. It owns the meter's enable and resol inputs and the oscillator-select mux.
- On each start it sweeps N_OSC oscillators in turn. For each one it settles the mux, runs one meter measurement, captures the count when lock rises and emits it as a tagged result over a valid/ready stream.
- A watchdog flags a meter that never locks.

---
 rtl/secuenciador_bias.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/secuenciador_bias.sv
// rtl/secuenciador_bias.sv - sweeps N_OSC oscillators through the GARO bias meter and streams tagged counts
module secuenciador_bias #(
    parameter int OUT_WIDTH   = 32,
    parameter int N_OSC       = 4,
    parameter int SEL_W       = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int WDOG_MARGIN = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [4:0]           resol_in,
    input  logic                 med_lock,
    input  logic [OUT_WIDTH-1:0] med_out,
    output logic                 med_enable,
    output logic [4:0]           med_resol,
    output logic [SEL_W-1:0]     osc_sel,
    output logic [OUT_WIDTH-1:0] dato,
    output logic [SEL_W-1:0]     dato_osc,
    output logic                 dato_valid,
    input  logic                 dato_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, EMIT} state_t;

    localparam int                CNT_W       = $clog2(SETTLE_CYC + 1);
    localparam logic [SEL_W-1:0]  LAST_OSC    = SEL_W'(N_OSC - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC);

    state_t                 state_q, state_d;
    logic [4:0]             resol_q, resol_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [SEL_W-1:0]       dosc_q, dosc_d;
    logic [OUT_WIDTH-1:0]   dato_q, dato_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [CNT_W-1:0]       settle_q, settle_d;
    logic [32:0]            wdog_q, wdog_d;
    logic [32:0]            wdog_limit;
    logic                   wdog_hit;

    // 33-bit compare so resol=31 plus the margin cannot wrap
    assign wdog_limit = (33'd1 << resol_q) + 33'(WDOG_MARGIN);
    assign wdog_hit   = (wdog_q + 33'd1) >= wdog_limit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            resol_q  <= '0;
            sel_q    <= '0;
            dosc_q   <= '0;
            dato_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            settle_q <= '0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            resol_q  <= resol_d;
            sel_q    <= sel_d;
            dosc_q   <= dosc_d;
            dato_q   <= dato_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            error_q  <= error_d;
            settle_q <= settle_d;
            wdog_q   <= wdog_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        resol_d  = resol_q;
        sel_d    = sel_q;
        dosc_d   = dosc_q;
        dato_d   = dato_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        error_d  = error_q;
        settle_d = settle_q;
        wdog_d   = wdog_q;

        if (abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        resol_d  = resol_in;
                        sel_d    = '0;
                        error_d  = 1'b0;
                        settle_d = SETTLE_LOAD;
                        state_d  = SETTLE;
                    end
                end
                SETTLE: begin
                    // a meter still reporting lock from the previous run must drop first
                    if (settle_q != '0) begin
                        settle_d = settle_q - CNT_W'(1);
                    end else if (!med_lock) begin
                        wdog_d  = '0;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    wdog_d = wdog_q + 33'd1;
                    if (med_lock) begin
                        dato_d  = med_out;
                        dosc_d  = sel_q;
                        valid_d = 1'b1;
                        state_d = EMIT;
                    end else if (wdog_hit) begin
                        error_d = 1'b1;
                        dato_d  = '1;
                        dosc_d  = sel_q;
                        valid_d = 1'b1;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (valid_q && dato_ready) begin
                        valid_d = 1'b0;
                        if (sel_q == LAST_OSC) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            sel_d    = sel_q + SEL_W'(1);
                            settle_d = SETTLE_LOAD;
                            state_d  = SETTLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign med_enable = (state_q == MEASURE);
    assign busy       = (state_q != IDLE);
    assign med_resol  = resol_q;
    assign osc_sel    = sel_q;
    assign dato       = dato_q;
    assign dato_osc   = dosc_q;
    assign dato_valid = valid_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
